// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, FIFO entry and write-source types for the writeback arbiter
package wb_arbiter_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DATA_W        = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_LNG  = 2'd3
    } wb_src_t;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry FIFO of pending long-latency register writes
module wb_fifo2
    import wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  wb_entry_t  push_entry,
    output wb_entry_t  head,
    output wb_entry_t  newest,
    output logic [1:0] count
);

    wb_entry_t mem [WB_FIFO_DEPTH];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      push_ok;
    logic      pop_ok;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head   = mem[rd_ptr];
    assign newest = mem[~wr_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile writeback arbiter (ALU > FIFO > long), optional bypass via WB_BYPASS_EN
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  lng_valid,
    output logic                  lng_ready,
    input  logic [REG_ADDR_W-1:0] lng_addr,
    input  logic [DATA_W-1:0]     lng_data,
    output logic                  w_enable,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0]     w_data,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] q_addr,
    output logic                  q_hit,
    output logic [DATA_W-1:0]     q_data
);

    logic [1:0] count;
    wb_entry_t  head;
    wb_entry_t  newest;
    wb_entry_t  lng_entry;
    wb_entry_t  sel_entry;
    wb_src_t    src;
    logic       alu_sel;
    logic       lng_take;
    logic       push;
    logic       pop;

    assign lng_ready = (count != 2'd2);
    assign busy      = (count != 2'd0);
    assign lng_entry = '{addr: lng_addr, data: lng_data};

    // Address-0 writes are accepted here and then simply never selected or queued.
    always_comb begin
        src      = SRC_NONE;
        alu_sel  = alu_valid && (alu_addr != '0);
        lng_take = lng_valid && lng_ready && (lng_addr != '0);
        pop      = 1'b0;
        if (alu_sel) begin
            src = SRC_ALU;
        end else if (busy) begin
            src = SRC_FIFO;
            pop = 1'b1;
        end else if (lng_take) begin
            src = SRC_LNG;
        end
        push = lng_take && (src != SRC_LNG);
    end

    always_comb begin
        sel_entry = lng_entry;
        case (src)
            SRC_ALU:  sel_entry = '{addr: alu_addr, data: alu_data};
            SRC_FIFO: sel_entry = head;
            default:  sel_entry = lng_entry;
        endcase
    end

    wb_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry (lng_entry),
        .head       (head),
        .newest     (newest),
        .count      (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_enable <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            w_enable <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                w_addr <= sel_entry.addr;
                w_data <= sel_entry.data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Newest pending value wins; with one entry head and newest are the same slot.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_addr != '0) begin
            if ((count != 2'd0) && (newest.addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = newest.data;
            end else if ((count == 2'd2) && (head.addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = head.data;
            end else if (w_enable && (w_addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = w_data;
            end
        end
    end
`else
    logic bypass_unused;
    assign bypass_unused = ^{q_addr, newest};
    assign q_hit         = 1'b0;
    assign q_data        = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table-driven self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_addr;
    logic [31:0] lng_data;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        busy;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    int checks;
    int failures;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lng_valid (lng_valid),
        .lng_ready (lng_ready),
        .lng_addr  (lng_addr),
        .lng_data  (lng_data),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_data    (q_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        lng_v;
        logic [4:0]  lng_a;
        logic [31:0] lng_d;
        logic [4:0]  q_a;
        logic        rdy;
        logic        bsy;
        logic        qh;
        logic [31:0] qd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic [4:0] qa, input logic rdy, input logic bsy,
        input logic qh, input logic [31:0] qd,
        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        vec_t v;
        v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
        v.lng_v = lv; v.lng_a = la; v.lng_d = ld;
        v.q_a = qa; v.rdy = rdy; v.bsy = bsy; v.qh = qh; v.qd = qd;
        v.we = we; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lng_valid = 1'b0; lng_addr = '0; lng_data = '0;
        q_addr = '0;
    endtask

    initial begin
        logic        eq_h;
        logic [31:0] eq_d;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive_idle();

        //          alu v a   d          lng v a  d          q   rdy bsy qh qd         we wa  wd
        vt[0]  = mk(0, 0,  32'h0,   0, 0, 32'h0,     0,  1, 0, 0, 32'h0,   0, 0,  32'h0);
        vt[1]  = mk(0, 0,  32'h0,   1, 3, 32'h33,    0,  1, 0, 0, 32'h0,   1, 3,  32'h33);
        vt[2]  = mk(0, 0,  32'h0,   0, 0, 32'h0,     3,  1, 0, 1, 32'h33,  0, 3,  32'h33);
        vt[3]  = mk(1, 5,  32'h55,  1, 6, 32'h66,    0,  1, 0, 0, 32'h0,   1, 5,  32'h55);
        vt[4]  = mk(0, 0,  32'h0,   0, 0, 32'h0,     6,  1, 1, 1, 32'h66,  1, 6,  32'h66);
        vt[5]  = mk(0, 0,  32'h0,   0, 0, 32'h0,     6,  1, 0, 1, 32'h66,  0, 6,  32'h66);
        vt[6]  = mk(1, 10, 32'hA0,  1, 7, 32'h70,    0,  1, 0, 0, 32'h0,   1, 10, 32'hA0);
        vt[7]  = mk(1, 11, 32'hB0,  1, 8, 32'h80,    0,  1, 1, 0, 32'h0,   1, 11, 32'hB0);
        vt[8]  = mk(1, 12, 32'hC0,  1, 9, 32'h90,    7,  0, 1, 1, 32'h70,  1, 12, 32'hC0);
        vt[9]  = mk(1, 13, 32'hD0,  1, 9, 32'h90,    12, 0, 1, 1, 32'hC0,  1, 13, 32'hD0);
        vt[10] = mk(0, 0,  32'h0,   1, 9, 32'h90,    0,  0, 1, 0, 32'h0,   1, 7,  32'h70);
        vt[11] = mk(0, 0,  32'h0,   1, 9, 32'h90,    0,  1, 1, 0, 32'h0,   1, 8,  32'h80);
        vt[12] = mk(0, 0,  32'h0,   0, 0, 32'h0,     0,  1, 1, 0, 32'h0,   1, 9,  32'h90);
        vt[13] = mk(0, 0,  32'h0,   0, 0, 32'h0,     0,  1, 0, 0, 32'h0,   0, 9,  32'h90);
        vt[14] = mk(1, 0,  32'hFFFF, 0, 0, 32'h0,    0,  1, 0, 0, 32'h0,   0, 9,  32'h90);
        vt[15] = mk(0, 0,  32'h0,   1, 0, 32'hFFFF,  0,  1, 0, 0, 32'h0,   0, 9,  32'h90);
        vt[16] = mk(1, 0,  32'hFFFF, 1, 0, 32'hFFFF, 0,  1, 0, 0, 32'h0,   0, 9,  32'h90);
        vt[17] = mk(0, 0,  32'h0,   0, 0, 32'h0,     0,  1, 0, 0, 32'h0,   0, 9,  32'h90);
        vt[18] = mk(1, 14, 32'hE0,  1, 0, 32'hFFFF,  0,  1, 0, 0, 32'h0,   1, 14, 32'hE0);
        vt[19] = mk(0, 0,  32'h0,   0, 0, 32'h0,     0,  1, 0, 0, 32'h0,   0, 14, 32'hE0);
        vt[20] = mk(1, 15, 32'hF0,  1, 4, 32'h1,     0,  1, 0, 0, 32'h0,   1, 15, 32'hF0);
        vt[21] = mk(1, 16, 32'h100, 1, 4, 32'h2,     0,  1, 1, 0, 32'h0,   1, 16, 32'h100);
        vt[22] = mk(1, 17, 32'h110, 0, 0, 32'h0,     4,  0, 1, 1, 32'h2,   1, 17, 32'h110);
        vt[23] = mk(0, 0,  32'h0,   0, 0, 32'h0,     4,  0, 1, 1, 32'h2,   1, 4,  32'h1);
        vt[24] = mk(0, 0,  32'h0,   0, 0, 32'h0,     4,  1, 1, 1, 32'h2,   1, 4,  32'h2);
        vt[25] = mk(0, 0,  32'h0,   0, 0, 32'h0,     4,  1, 0, 1, 32'h2,   0, 4,  32'h2);
        vt[26] = mk(0, 0,  32'h0,   0, 0, 32'h0,     4,  1, 0, 0, 32'h0,   0, 4,  32'h2);

        repeat (2) @(negedge clk);
        #1;
        check("reset_w_enable", {31'b0, w_enable}, 32'd0);
        check("reset_w_addr", {27'b0, w_addr}, 32'd0);
        check("reset_w_data", w_data, 32'd0);
        check("reset_lng_ready", {31'b0, lng_ready}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_q_hit", {31'b0, q_hit}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            alu_valid = vt[i].alu_v; alu_addr = vt[i].alu_a; alu_data = vt[i].alu_d;
            lng_valid = vt[i].lng_v; lng_addr = vt[i].lng_a; lng_data = vt[i].lng_d;
            q_addr    = vt[i].q_a;
`ifdef WB_BYPASS_EN
            eq_h = vt[i].qh; eq_d = vt[i].qd;
`else
            eq_h = 1'b0; eq_d = 32'h0;
`endif
            #1;
            check($sformatf("v%0d_lng_ready", i), {31'b0, lng_ready}, {31'b0, vt[i].rdy});
            check($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vt[i].bsy});
            check($sformatf("v%0d_q_hit", i), {31'b0, q_hit}, {31'b0, eq_h});
            check($sformatf("v%0d_q_data", i), q_data, eq_d);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_w_enable", i), {31'b0, w_enable}, {31'b0, vt[i].we});
            check($sformatf("v%0d_w_addr", i), {27'b0, w_addr}, {27'b0, vt[i].wa});
            check($sformatf("v%0d_w_data", i), w_data, vt[i].wd);
        end

        // Fill the FIFO behind ALU traffic, then reset asynchronously mid-cycle.
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h200;
        lng_valid = 1'b1; lng_addr = 5'd21; lng_data = 32'h210;
        @(negedge clk);
        alu_addr = 5'd22; alu_data = 32'h220;
        lng_addr = 5'd23; lng_data = 32'h230;
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1; alu_addr = 5'd24; alu_data = 32'h240;
        #1;
        check("full_lng_ready", {31'b0, lng_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("pre_reset_w_enable", {31'b0, w_enable}, 32'd1);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        check("arst_w_enable", {31'b0, w_enable}, 32'd0);
        check("arst_w_addr", {27'b0, w_addr}, 32'd0);
        check("arst_w_data", w_data, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_lng_ready", {31'b0, lng_ready}, 32'd1);
        check("arst_q_hit", {31'b0, q_hit}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d_w_enable", k), {31'b0, w_enable}, 32'd0);
            check($sformatf("post_reset%0d_busy", k), {31'b0, busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
